i2s_transmitter: RTL and testbench
==================================

Name: i2s_transmitter

Overview:
- Serialises the 16-bit stereo audio_l/audio_r output of the mixer/compressor chain into a standard Philips I2S stream for the external audio DAC.
- Generates BCLK/LRCK from the system clock, captures one stereo sample per frame, and shifts it out MSB-first.
- Sits directly downstream of the compressor; its outputs go straight to FPGA pins.

Parameters:
- BCLK_DIV, 8, clk cycles per BCLK half-period (>=1); BCLK = clk/(2*BCLK_DIV), Fs = clk/(64*BCLK_DIV)
- MCLK_DIV, 2, clk cycles per MCLK half-period (>=1); used only with I2S_MCLK_EN

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- audio_l  in  16  left sample, two's complement, from compressor
- audio_r  in  16  right sample, two's complement, from compressor
- mute  in  1  forces the next captured sample pair to zero
- sample_stb  out  1  one-clk pulse when a new sample pair is captured
- i2s_bclk  out  1  bit clock
- i2s_lrck  out  1  word select; 0 = left, 1 = right
- i2s_data  out  1  serial data
- i2s_mclk  out  1  master clock (I2S_MCLK_EN only; tied 0 otherwise)

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low, sampled on rising clk.
- Reset values:
  - i2s_bclk=0, i2s_lrck=0, i2s_data=0, sample_stb=0
  - div_cnt=0, slot=30, shift/hold registers=0
- Divider:
  - div_cnt counts 0..BCLK_DIV-1; on terminal count it wraps to 0 and i2s_bclk toggles.
  - Rising BCLK: no state change; data must be stable.
  - Falling BCLK (toggle from 1 to 0) is the "fall event". All slot, lrck and data updates occur in the same clk as the fall event, registered.
- Slot counter: 5 bits, increments by 1 on each fall event, wraps 31->0. A frame is 32 slots.
- LRCK: 0 for slots 31,0..14; 1 for slots 15..30. This gives the I2S one-bit delay before each MSB.
- Data:
  - Slot k in 0..15: left_hold[15-k].
  - Slot k in 16..31: right_hold[31-k].
  - Slot 31 carries right LSB of the current frame.
- Capture:
  - On the fall event entering slot 31, audio_l/audio_r are latched into the next-frame registers (zero if mute=1).
  - sample_stb pulses for exactly that one clk.
  - The next-frame registers transfer to left_hold/right_hold on the fall event entering slot 0.
  - Inputs and mute changes at any other time have no effect on the current frame.
- Latency:
  - Captured left MSB appears on i2s_data 1 BCLK period after capture.
  - Right MSB appears 17 BCLK periods after capture.
- After reset:
  - First rising BCLK occurs BCLK_DIV clks after rst_n deasserts; first fall event follows 2*BCLK_DIV clks after deassert.
  - That first fall event enters slot 31: capture and sample_stb occur there.
- Reset mid-frame: all outputs return to reset values on the next clk; the partial frame is abandoned with no glitch beyond the truncated BCLK.
- BCLK_DIV=1: BCLK toggles every clk; behaviour is otherwise identical.

Optional Feature:
- I2S_MCLK_EN defined:
  - Separate counter 0..MCLK_DIV-1 toggles i2s_mclk on wrap; reset value 0.
  - Free-running and unrelated to BCLK phase, except that both restart at reset.
- Not defined: i2s_mclk is constant 0 and the counter is absent.

Decomposition:
- Shared audio package:
  - I2S_SLOTS=32, I2S_WORD=16
  - LRCK_FALL_SLOT=31, LRCK_RISE_SLOT=15
  - sample type: 16-bit signed
- Sub-module i2s_clkgen: divider plus fall-event strobe and optional MCLK. The parent holds the slot counter, capture and shift logic.

Test Plan:
- Reset, BCLK_DIV=2, audio_l=16'hA5C3, audio_r=16'h5A3C held -> first sample_stb at clk 4 after rst_n high; next frame's i2s_data bits decode to L=A5C3, R=5A3C; BCLK period 4 clk.
- Frame timing -> LRCK falls at the same clk as data switches to the previous right LSB; left MSB is on the next fall event; frame = 128 clk; sample_stb period 128 clk.
- Change audio_l to 16'h8000 at slot 5 -> current frame unaffected; following frame left = 8000.
- mute=1 across a capture point -> the next frame carries L=R=0000; mute=0 before the following capture -> normal data resumes.
- Assert rst_n=0 at slot 20 for 1 clk -> next clk all outputs 0; restart timing identical to the first scenario.
- With I2S_MCLK_EN, MCLK_DIV=1 -> i2s_mclk toggles every clk from reset; without the macro -> i2s_mclk constantly 0.

Source files
------------

// File: rtl/i2s_transmitter_pkg.sv
// Shared audio definitions for the I2S transmitter: frame geometry, sample types
// and slot-to-LRCK/data mapping helpers.
package i2s_transmitter_pkg;

    localparam int I2S_SLOTS = 32;
    localparam int I2S_WORD  = 16;

    typedef logic [$clog2(I2S_SLOTS)-1:0] slot_t;

    localparam slot_t LRCK_FALL_SLOT = slot_t'(31);
    localparam slot_t LRCK_RISE_SLOT = slot_t'(15);

    typedef logic signed [I2S_WORD-1:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

    // LRCK leads each word by one slot, so it is high for slots 15..30.
    function automatic logic lrck_for_slot(input slot_t s);
        return (s >= LRCK_RISE_SLOT) && (s != LRCK_FALL_SLOT);
    endfunction

    function automatic logic slot_bit(input stereo_t f, input slot_t s);
        logic [3:0] idx;
        idx = ~s[3:0];
        return s[4] ? f.r[idx] : f.l[idx];
    endfunction

endpackage

// File: rtl/i2s_transmitter_clkgen.sv
// BCLK divider with fall-event strobe; optional free-running MCLK when
// I2S_MCLK_EN is defined (otherwise MCLK is tied low).
module i2s_clkgen #(
    parameter int BCLK_DIV = 8,
    parameter int MCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_bclk,
    output logic o_fall,
    output logic o_mclk
);

    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [DW-1:0] r_div_cnt;
    logic          r_bclk;
    logic          w_wrap;

    assign w_wrap = (r_div_cnt == DW'(BCLK_DIV - 1));
    // High during the clk whose rising edge drives BCLK from 1 to 0.
    assign o_fall = w_wrap & r_bclk;
    assign o_bclk = r_bclk;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (w_wrap) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

`ifdef I2S_MCLK_EN
    localparam int MW = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;

    logic [MW-1:0] r_mclk_cnt;
    logic          r_mclk;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mclk_cnt <= '0;
            r_mclk     <= 1'b0;
        end else if (r_mclk_cnt == MW'(MCLK_DIV - 1)) begin
            r_mclk_cnt <= '0;
            r_mclk     <= ~r_mclk;
        end else begin
            r_mclk_cnt <= r_mclk_cnt + 1'b1;
        end
    end

    assign o_mclk = r_mclk;
`else
    assign o_mclk = 1'b0;
`endif

endmodule

// File: rtl/i2s_transmitter.sv
// Philips I2S serialiser: captures one stereo pair per 32-slot frame and shifts it
// out MSB-first. MCLK output is enabled by defining I2S_MCLK_EN.
module i2s_transmitter
    import i2s_transmitter_pkg::*;
#(
    parameter int BCLK_DIV = 8,
    parameter int MCLK_DIV = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [I2S_WORD-1:0] audio_l,
    input  logic [I2S_WORD-1:0] audio_r,
    input  logic                mute,
    output logic                sample_stb,
    output logic                i2s_bclk,
    output logic                i2s_lrck,
    output logic                i2s_data,
    output logic                i2s_mclk
);

    logic    w_fall;
    logic    w_capture;
    logic    w_load;
    logic    w_data_nxt;
    slot_t   w_slot_nxt;

    slot_t   r_slot;
    logic    r_lrck;
    logic    r_data;
    logic    r_stb;
    stereo_t r_next;
    stereo_t r_hold;

    i2s_clkgen #(
        .BCLK_DIV (BCLK_DIV),
        .MCLK_DIV (MCLK_DIV)
    ) u_clkgen (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_bclk (i2s_bclk),
        .o_fall (w_fall),
        .o_mclk (i2s_mclk)
    );

    assign w_slot_nxt = r_slot + 1'b1;
    assign w_capture  = w_fall && (w_slot_nxt == LRCK_FALL_SLOT);
    assign w_load     = w_fall && (w_slot_nxt == '0);
    // Hold registers load on this same edge, so slot 0 takes its MSB from r_next.
    assign w_data_nxt = w_load ? r_next.l[I2S_WORD-1] : slot_bit(r_hold, w_slot_nxt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot <= slot_t'(30);
            r_lrck <= 1'b0;
            r_data <= 1'b0;
            r_stb  <= 1'b0;
            r_next <= '0;
            r_hold <= '0;
        end else begin
            r_stb <= w_capture;
            if (w_fall) begin
                r_slot <= w_slot_nxt;
                r_lrck <= lrck_for_slot(w_slot_nxt);
                r_data <= w_data_nxt;
            end
            if (w_capture) begin
                r_next <= mute ? stereo_t'('0) : stereo_t'({audio_l, audio_r});
            end
            if (w_load) begin
                r_hold <= r_next;
            end
        end
    end

    assign sample_stb = r_stb;
    assign i2s_lrck   = r_lrck;
    assign i2s_data   = r_data;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter at BCLK_DIV=2, MCLK_DIV=1; decodes frames by
// sampling data once per slot at absolute clk counts after reset release.
module tb_i2s_transmitter;

    localparam int BD    = 2;
    localparam int FRAME = 64 * BD;
    localparam int BPER  = 2 * BD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] audio_l = 16'hA5C3;
    logic [15:0] audio_r = 16'h5A3C;
    logic        mute = 1'b0;
    logic        sample_stb, i2s_bclk, i2s_lrck, i2s_data, i2s_mclk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int bclk_bad = 0;
    int stb_bad = 0;
    int mclk_bad = 0;

    logic [15:0] fl, fr;
    logic [31:0] flr;

    i2s_transmitter #(
        .BCLK_DIV (BD),
        .MCLK_DIV (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .audio_l    (audio_l),
        .audio_r    (audio_r),
        .mute       (mute),
        .sample_stb (sample_stb),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrck   (i2s_lrck),
        .i2s_data   (i2s_data),
        .i2s_mclk   (i2s_mclk)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to clk edge n after reset release, sampling on each falling clk.
    task automatic goto(input int n);
        logic exp_mclk;
        while (cyc < n) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
`ifdef I2S_MCLK_EN
            exp_mclk = (cyc % 2) == 1;
`else
            exp_mclk = 1'b0;
`endif
            if (i2s_bclk !== (((cyc / BD) % 2) == 1)) bclk_bad++;
            if (sample_stb !== ((cyc % FRAME) == 2 * BD)) stb_bad++;
            if (i2s_mclk !== exp_mclk) mclk_bad++;
        end
    endtask

    function automatic int cap_edge(input int m);
        return 2 * BD + FRAME * m;
    endfunction

    task automatic read_frame(input int m, input int chg_slot, input logic [15:0] chg_l,
                              input logic chg_mute, output logic [15:0] l,
                              output logic [15:0] r, output logic [31:0] lr);
        for (int s = 0; s < 32; s++) begin
            goto(cap_edge(m) + BPER * (s + 1));
            if (s < 16) l[15 - s] = i2s_data;
            else        r[31 - s] = i2s_data;
            lr[s] = i2s_lrck;
            if (s == chg_slot) begin
                audio_l = chg_l;
                mute    = chg_mute;
            end
        end
    endtask

    task automatic startup(input string tag);
        goto(1);
        chk({tag, "_bclk_e1"}, 32'(i2s_bclk), 32'd0);
        chk({tag, "_stb_e1"}, 32'(sample_stb), 32'd0);
        goto(BD);
        chk({tag, "_bclk_rise"}, 32'(i2s_bclk), 32'd1);
        goto(2 * BD - 1);
        chk({tag, "_stb_pre"}, 32'(sample_stb), 32'd0);
        goto(2 * BD);
        chk({tag, "_stb_first"}, 32'(sample_stb), 32'd1);
        chk({tag, "_bclk_fall"}, 32'(i2s_bclk), 32'd0);
        chk({tag, "_lrck_first"}, 32'(i2s_lrck), 32'd0);
        chk({tag, "_data_first"}, 32'(i2s_data), 32'd0);
        goto(2 * BD + 1);
        chk({tag, "_stb_pulse"}, 32'(sample_stb), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_bclk", 32'(i2s_bclk), 32'd0);
        chk("rst_lrck", 32'(i2s_lrck), 32'd0);
        chk("rst_data", 32'(i2s_data), 32'd0);
        chk("rst_stb", 32'(sample_stb), 32'd0);
        chk("rst_mclk", 32'(i2s_mclk), 32'd0);

        rst_n = 1'b1;
        cyc = 0;
        startup("s0");

        read_frame(0, -1, 16'h0, 1'b0, fl, fr, flr);
        chk("f0_left", 32'(fl), 32'h0000A5C3);
        chk("f0_right", 32'(fr), 32'h00005A3C);
        chk("f0_lrck", flr, 32'h7FFF8000);

        // Left input changes mid-frame: current frame keeps old capture.
        read_frame(1, 5, 16'h8000, 1'b0, fl, fr, flr);
        chk("f1_left", 32'(fl), 32'h0000A5C3);
        chk("f1_right", 32'(fr), 32'h00005A3C);

        // Mute raised before the next capture.
        read_frame(2, 20, 16'h8000, 1'b1, fl, fr, flr);
        chk("f2_left", 32'(fl), 32'h00008000);
        chk("f2_right", 32'(fr), 32'h00005A3C);
        chk("f2_lrck", flr, 32'h7FFF8000);

        read_frame(3, 10, 16'h8000, 1'b0, fl, fr, flr);
        chk("f3_mute_left", 32'(fl), 32'h00000000);
        chk("f3_mute_right", 32'(fr), 32'h00000000);

        read_frame(4, -1, 16'h0, 1'b0, fl, fr, flr);
        chk("f4_left", 32'(fl), 32'h00008000);
        chk("f4_right", 32'(fr), 32'h00005A3C);

        chk("bclk_wave", 32'(bclk_bad), 32'd0);
        chk("stb_period", 32'(stb_bad), 32'd0);
        chk("mclk_wave", 32'(mclk_bad), 32'd0);

        // One-clk reset in slot 20 of frame 5.
        goto(cap_edge(5) + BPER * 21);
        chk("pre_rst_lrck", 32'(i2s_lrck), 32'd1);
        rst_n   = 1'b0;
        audio_l = 16'hA5C3;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_bclk", 32'(i2s_bclk), 32'd0);
        chk("mid_rst_lrck", 32'(i2s_lrck), 32'd0);
        chk("mid_rst_data", 32'(i2s_data), 32'd0);
        chk("mid_rst_stb", 32'(sample_stb), 32'd0);
        chk("mid_rst_mclk", 32'(i2s_mclk), 32'd0);
        rst_n = 1'b1;
        cyc = 0;
        bclk_bad = 0;
        stb_bad = 0;
        mclk_bad = 0;
        startup("s1");

        read_frame(0, -1, 16'h0, 1'b0, fl, fr, flr);
        chk("r0_left", 32'(fl), 32'h0000A5C3);
        chk("r0_right", 32'(fr), 32'h00005A3C);
        chk("r0_lrck", flr, 32'h7FFF8000);
        goto(cap_edge(1) + 2);
        chk("r_bclk_wave", 32'(bclk_bad), 32'd0);
        chk("r_stb_period", 32'(stb_bad), 32'd0);
        chk("r_mclk_wave", 32'(mclk_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
